// File: rtl/fpga_rst_pkg.sv
// Shared encodings for the board reset sequencer: FSM states, reset causes,
// and the priority rule used when several abort sources fire together.
package fpga_rst_pkg;

  typedef enum logic [1:0] {
    ST_HOLD    = 2'd0,
    ST_RELEASE = 2'd1,
    ST_RUN     = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_POR  = 2'd0,
    CAUSE_LOCK = 2'd1,
    CAUSE_EXT  = 2'd2,
    CAUSE_SW   = 2'd3
  } cause_e;

  // Lock loss outranks the button, which outranks software.
  function automatic cause_e abort_cause(input logic locked, input logic ext, input logic sw);
    cause_e c;
    c = CAUSE_SW;
    if (ext) c = CAUSE_EXT;
    if (!locked) c = CAUSE_LOCK;
    return c;
  endfunction

endpackage

// File: rtl/fpga_rst_debounce.sv
// Synchronises and debounces the reset push-button into a single-cycle request.
// Latency: 2 sync edges + DEBOUNCE_CYC edges; re-arms only after the input returns low.
module fpga_rst_debounce #(
  parameter int CNT_W        = 16,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic req_pulse
);

  localparam logic [CNT_W-1:0] DEB_LAST = CNT_W'(DEBOUNCE_CYC);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_q, req_d;

  // The counter parks at DEB_LAST while held so it can neither wrap nor re-fire.
  always_comb begin
    cnt_d = '0;
    if (sync2_q) cnt_d = (cnt_q == DEB_LAST) ? cnt_q : cnt_q + 1'b1;
    req_d = (cnt_d == DEB_LAST) && (cnt_q != DEB_LAST);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      sync1_q <= din;
      sync2_q <= sync1_q;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign req_pulse = req_q;

endmodule

// File: rtl/fpga_rst_seq.sv
// Board reset sequencer: holds all domains until lock + HOLD_CYC, then releases bit 0 upward every STAGGER_CYC.
// Abort (lock loss, button, software) re-asserts everything on the next edge; all outputs registered.
module fpga_rst_seq
  import fpga_rst_pkg::*;
#(
  parameter int N_CH         = 4,
  parameter int CNT_W        = 16,
  parameter int HOLD_CYC     = 750,
  parameter int STAGGER_CYC  = 16,
  parameter int DEBOUNCE_CYC = 8
) (
  input  logic            CLK100MHZ,
  input  logic            ck_rst,
  input  logic            pll_locked,
  input  logic            ext_rst_req,
  input  logic            sw_rst_req,
  output logic [N_CH-1:0] rst_out,
  output logic            rst_done,
  output logic [1:0]      seq_state,
  output logic [1:0]      rst_cause
);

  localparam int               IDX_W      = (N_CH > 1) ? $clog2(N_CH) : 1;
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] STAG_LAST  = CNT_W'(STAGGER_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_CH - 1);

  state_e           state_q, state_d;
  cause_e           rst_cause_q, rst_cause_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [N_CH-1:0]  rst_out_q, rst_out_d;
  logic             rst_done_q, rst_done_d;
  logic             ext_req_q;
  logic             abort;

  fpga_rst_debounce #(
    .CNT_W       (CNT_W),
    .DEBOUNCE_CYC(DEBOUNCE_CYC)
  ) u_debounce (
    .clk      (CLK100MHZ),
    .rst      (ck_rst),
    .din      (ext_rst_req),
    .req_pulse(ext_req_q)
  );

  assign abort = !pll_locked | ext_req_q | sw_rst_req;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    rst_out_d   = rst_out_q;
    rst_done_d  = rst_done_q;
    rst_cause_d = rst_cause_q;
    // Abort is evaluated first so it also beats a release due on this edge.
    if (abort) begin
      state_d     = ST_HOLD;
      cnt_d       = '0;
      idx_d       = '0;
      rst_out_d   = '1;
      rst_done_d  = 1'b0;
      rst_cause_d = abort_cause(pll_locked, ext_req_q, sw_rst_req);
    end else begin
      case (state_q)
        ST_HOLD: begin
          if (cnt_q == HOLD_LAST) begin
            rst_out_d[0] = 1'b0;
            cnt_d        = '0;
            if (N_CH == 1) begin
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end else begin
              state_d = ST_RELEASE;
              idx_d   = IDX_W'(1);
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RELEASE: begin
          if (cnt_q == STAG_LAST) begin
            rst_out_d[idx_q] = 1'b0;
            cnt_d            = '0;
            idx_d            = idx_q + 1'b1;
            if (idx_q == IDX_LAST) begin
              state_d    = ST_RUN;
              rst_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
        ST_RUN: ;
        default: begin
          state_d    = ST_HOLD;
          cnt_d      = '0;
          idx_d      = '0;
          rst_out_d  = '1;
          rst_done_d = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK100MHZ) begin
    if (ck_rst) begin
      state_q     <= ST_HOLD;
      cnt_q       <= '0;
      idx_q       <= '0;
      rst_out_q   <= '1;
      rst_done_q  <= 1'b0;
      rst_cause_q <= CAUSE_POR;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      rst_out_q   <= rst_out_d;
      rst_done_q  <= rst_done_d;
      rst_cause_q <= rst_cause_d;
    end
  end

  assign rst_out   = rst_out_q;
  assign rst_done  = rst_done_q;
  assign seq_state = state_q;
  assign rst_cause = rst_cause_q;

endmodule

// File: tb/tb_fpga_rst_seq.sv
// Directed bench for fpga_rst_seq: a 4-domain instance carries every scenario,
// a 1-domain instance on the same inputs covers the direct HOLD->RUN path.
module tb_fpga_rst_seq;

  logic       clk = 1'b0;
  logic       ck_rst, pll_locked, ext_rst_req, sw_rst_req;
  logic [3:0] rst_out4;
  logic       rst_done4;
  logic [1:0] seq_state4, rst_cause4;
  logic [0:0] rst_out1;
  logic       rst_done1;
  logic [1:0] seq_state1, rst_cause1;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fpga_rst_seq #(.N_CH(4), .CNT_W(16), .HOLD_CYC(8), .STAGGER_CYC(4), .DEBOUNCE_CYC(4)) dut4 (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .pll_locked(pll_locked), .ext_rst_req(ext_rst_req),
    .sw_rst_req(sw_rst_req), .rst_out(rst_out4), .rst_done(rst_done4),
    .seq_state(seq_state4), .rst_cause(rst_cause4));

  fpga_rst_seq #(.N_CH(1), .CNT_W(16), .HOLD_CYC(8), .STAGGER_CYC(4), .DEBOUNCE_CYC(4)) dut1 (
    .CLK100MHZ(clk), .ck_rst(ck_rst), .pll_locked(pll_locked), .ext_rst_req(ext_rst_req),
    .sw_rst_req(sw_rst_req), .rst_out(rst_out1), .rst_done(rst_done1),
    .seq_state(seq_state1), .rst_cause(rst_cause1));

  typedef struct {
    int         k;
    logic [3:0] out4;
    logic       done4;
    logic [1:0] st4;
    logic       out1;
    logic       done1;
    logic [1:0] st1;
  } vec_t;

  vec_t tbl[10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  // Assumes the next edge is t0 (HOLD, cnt 0, locked, no abort pending).
  task automatic expect_release(input string name, input logic [1:0] cause);
    for (int k = 0; k < 20; k++) begin
      step();
      case (k)
        6:  check({name, " k6 out"},  rst_out4, 4'b1111);
        7:  check({name, " k7 out"},  rst_out4, 4'b1110);
        11: check({name, " k11 out"}, rst_out4, 4'b1100);
        15: check({name, " k15 out"}, rst_out4, 4'b1000);
        18: check({name, " k18 done"}, rst_done4, 1'b0);
        19: begin
          check({name, " k19 out"},   rst_out4, 4'b0000);
          check({name, " k19 done"},  rst_done4, 1'b1);
          check({name, " k19 state"}, seq_state4, 2'd2);
          check({name, " k19 cause"}, rst_cause4, cause);
        end
        default: ;
      endcase
    end
  endtask

  initial begin
    tbl[0] = '{0,  4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0};
    tbl[1] = '{6,  4'b1111, 1'b0, 2'd0, 1'b1, 1'b0, 2'd0};
    tbl[2] = '{7,  4'b1110, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[3] = '{10, 4'b1110, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[4] = '{11, 4'b1100, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[5] = '{14, 4'b1100, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[6] = '{15, 4'b1000, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[7] = '{18, 4'b1000, 1'b0, 2'd1, 1'b0, 1'b1, 2'd2};
    tbl[8] = '{19, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2};
    tbl[9] = '{25, 4'b0000, 1'b1, 2'd2, 1'b0, 1'b1, 2'd2};

    ck_rst = 1'b1; pll_locked = 1'b1; ext_rst_req = 1'b0; sw_rst_req = 1'b0;
    step_n(3);
    check("reset out",   rst_out4, 4'b1111);
    check("reset done",  rst_done4, 1'b0);
    check("reset state", seq_state4, 2'd0);
    check("reset cause", rst_cause4, 2'd0);
    check("reset out1",  rst_out1, 1'b1);

    // Power-on: next edge is t0.
    ck_rst = 1'b0;
    begin
      int ti;
      ti = 0;
      for (int k = 0; k <= 25; k++) begin
        step();
        if (ti < 10 && tbl[ti].k == k) begin
          check($sformatf("por k%0d out4", k),  rst_out4,   tbl[ti].out4);
          check($sformatf("por k%0d done4", k), rst_done4,  tbl[ti].done4);
          check($sformatf("por k%0d st4", k),   seq_state4, tbl[ti].st4);
          check($sformatf("por k%0d cause4", k), rst_cause4, 2'd0);
          check($sformatf("por k%0d out1", k),  rst_out1,   tbl[ti].out1);
          check($sformatf("por k%0d done1", k), rst_done1,  tbl[ti].done1);
          check($sformatf("por k%0d st1", k),   seq_state1, tbl[ti].st1);
          ti++;
        end
      end
    end

    // Lock loss mid-HOLD: 3 locked edges, 3 unlocked, release 3+3 edges late.
    ck_rst = 1'b1;
    step();
    check("ckrst run out",   rst_out4, 4'b1111);
    check("ckrst run state", seq_state4, 2'd0);
    ck_rst = 1'b0;
    step_n(3);
    pll_locked = 1'b0;
    step_n(3);
    check("lock drop out",   rst_out4, 4'b1111);
    check("lock drop cause", rst_cause4, 2'd1);
    pll_locked = 1'b1;
    expect_release("lockloss", 2'd1);

    // Software pulse in RUN.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    check("sw out",   rst_out4, 4'b1111);
    check("sw done",  rst_done4, 1'b0);
    check("sw cause", rst_cause4, 2'd3);
    check("sw state", seq_state4, 2'd0);
    expect_release("sw", 2'd3);

    // Button glitch one cycle shorter than the debounce window.
    ext_rst_req = 1'b1;
    step_n(3);
    ext_rst_req = 1'b0;
    step_n(10);
    check("glitch out",  rst_out4, 4'b0000);
    check("glitch done", rst_done4, 1'b1);

    // Held button: 2 sync + 4 debounce + 1 assert edges.
    ext_rst_req = 1'b1;
    step_n(6);
    check("ext early out", rst_out4, 4'b0000);
    step();
    check("ext out",   rst_out4, 4'b1111);
    check("ext cause", rst_cause4, 2'd2);
    expect_release("ext", 2'd2);
    step_n(30);
    check("ext held done",  rst_done4, 1'b1);
    check("ext held state", seq_state4, 2'd2);
    ext_rst_req = 1'b0;
    step_n(3);

    // Lock loss + sw on the edge that would release bit 1.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    step_n(11);
    check("simul pre out", rst_out4, 4'b1110);
    pll_locked = 1'b0;
    sw_rst_req = 1'b1;
    step();
    check("simul out",   rst_out4, 4'b1111);
    check("simul cause", rst_cause4, 2'd1);
    check("simul state", seq_state4, 2'd0);
    pll_locked = 1'b1;
    sw_rst_req = 1'b0;
    expect_release("simul", 2'd1);

    // ck_rst mid-RELEASE.
    sw_rst_req = 1'b1;
    step();
    sw_rst_req = 1'b0;
    step_n(10);
    check("mid rel state", seq_state4, 2'd1);
    ck_rst = 1'b1;
    step();
    check("ckrst rel state", seq_state4, 2'd0);
    check("ckrst rel out",   rst_out4, 4'b1111);
    check("ckrst rel cause", rst_cause4, 2'd0);
    check("ckrst rel done",  rst_done4, 1'b0);
    ck_rst = 1'b0;
    expect_release("after ckrst", 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
